// File: rtl/seq_mul_if.sv
// Request/response bundle for the sequential multiplier: operands and start in,
// busy/done/product back.
interface seq_mul_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, sgn, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_mul.sv
// Radix-2 Booth sequential multiplier, signed or unsigned, one iteration per clock.
// The WIDTH+1 iterations run on operands extended to WIDTH+1 bits.
module seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  seq_mul_if.slave   bus
);

  localparam int unsigned XW  = WIDTH + 1;       // extended operand width
  localparam int unsigned AW  = XW + 1;          // accumulator, one spare bit so +/-A never overflows
  localparam int unsigned PW  = AW + XW;         // {accumulator, multiplier}
  localparam int unsigned PRW = 2 * WIDTH;       // product width
  localparam int unsigned CW  = $clog2(XW + 1);  // iteration counter width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [XW-1:0]    a_q, a_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             guard_q, guard_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PRW-1:0]   p_q, p_d;

  logic [XW-1:0]    a_ext;
  logic [XW-1:0]    b_ext;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    a_wide;
  logic [AW-1:0]    sum;
  logic [PW-1:0]    sum_full;
  logic [PW-1:0]    step_prod;

  // Operand extension chosen by the requested mode
  always_comb begin
    a_ext = bus.sgn ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
    b_ext = bus.sgn ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
  end

  // One Booth iteration: add 0/+A/-A to the upper half, then arithmetic shift right
  always_comb begin
    acc    = prod_q[PW-1 -: AW];
    a_wide = {a_q[XW-1], a_q};
    unique case ({prod_q[0], guard_q})
      2'b01:   sum = acc + a_wide;
      2'b10:   sum = acc - a_wide;
      default: sum = acc;
    endcase
    sum_full  = {sum, prod_q[XW-1:0]};
    step_prod = {sum_full[PW-1], sum_full[PW-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    prod_d  = prod_q;
    guard_d = guard_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = a_ext;
          prod_d  = {AW'(0), b_ext};
          guard_d = 1'b0;
          cnt_d   = CW'(XW);
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d  = step_prod;
        guard_d = prod_q[0];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          p_d     = step_prod[PRW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      prod_q  <= '0;
      guard_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      prod_q  <= prod_d;
      guard_q <= guard_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      p_q     <= p_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: the driver queues expected products with their
// completion cycle, a monitor checks busy/done/p every cycle against that queue.
module tb_seq_mul;

  localparam int unsigned W = 8;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [2*W-1:0] last_p = '0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_if #(.WIDTH(W)) bus ();

  seq_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [2*W-1:0] ref_mul(logic s, logic [W-1:0] x, logic [W-1:0] y);
    longint px, py;
    if (s) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    return (2*W)'(px * py);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: expected busy/done derive from the head of the scoreboard queue
  always @(negedge clk) begin
    logic eb, ed;
    ed = (q.size() > 0) && (q[0].due == cyc);
    eb = (q.size() > 0) && (cyc < q[0].due);
    if (ed) begin
      last_p = q[0].p;
      void'(q.pop_front());
    end
    check("busy", 64'(bus.busy), 64'(eb));
    check("done", 64'(bus.done), 64'(ed));
    check("p", 64'(bus.p), 64'(last_p));
    check("done_busy_excl", 64'(bus.done & bus.busy), 64'(0));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      step();
      t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: got %0d pending expected 0 (cycle %0d)", q.size(), cyc);
      q.delete();
    end
  endtask

  // Launch one operation from an idle point; operands are scrambled after acceptance
  task automatic issue(logic s, logic [W-1:0] x, logic [W-1:0] y);
    wait_idle();
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a     = x;
    bus.b     = y;
    q.push_back('{ref_mul(s, x, y), cyc + int'(W) + 2});
    step();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.sgn   = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    step();
    step();
    rst = 1'b0;

    // Corner products
    issue(1'b0, 8'hFF, 8'hFF);
    issue(1'b1, 8'h80, 8'h80);
    issue(1'b1, 8'hFF, 8'h7F);
    issue(1'b1, 8'h80, 8'h01);
    issue(1'b0, 8'hFF, 8'h02);
    issue(1'b1, 8'hFF, 8'h02);
    wait_idle();
    step();

    // Start pulse during a run must be ignored
    issue(1'b0, 8'd3, 8'd5);
    step();
    step();
    bus.start = 1'b1;
    bus.a = 8'd7;
    bus.b = 8'd7;
    step();
    bus.start = 1'b0;
    wait_idle();
    repeat (3) step();

    // Reset in the middle of an operation
    issue(1'b0, 8'h12, 8'h34);
    step();
    step();
    step();
    rst = 1'b1;
    q.delete();
    last_p = '0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_p", 64'(bus.p), 64'(0));
    step();
    step();
    rst = 1'b0;
    issue(1'b1, 8'h12, 8'hC4);
    wait_idle();

    // Held start: back-to-back operations with no idle gap
    bus.sgn = 1'b0;
    bus.a = 8'd2;
    bus.b = 8'd3;
    bus.start = 1'b1;
    n = 0;
    for (int t = 0; t < 100 && n < 4; t++) begin
      if (q.size() == 0) begin
        q.push_back('{ref_mul(1'b0, 8'd2, 8'd3), cyc + int'(W) + 2});
        n++;
      end
      step();
    end
    bus.start = 1'b0;
    wait_idle();

    // Random operands, modes, gaps and stray starts
    for (int i = 0; i < 60; i++) begin
      logic s;
      logic [W-1:0] x, y;
      s = 1'($urandom);
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(0, 7))
        0: x = {1'b1, {(W-1){1'b0}}};
        1: y = {W{1'b1}};
        2: x = '0;
        default: ;
      endcase
      issue(s, x, y);
      if ($urandom_range(0, 3) == 0) begin
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) step();
      end
    end

    wait_idle();
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
